// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, branch/jump and data-memory-wait hazard control for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemRead_ID_EX,
    input  logic [4:0]  Rt_ID_EX,
    input  logic [4:0]  Rs_IF_ID,
    input  logic [4:0]  Rt_IF_ID,
    input  logic        UsesRs_IF_ID,
    input  logic        UsesRt_IF_ID,
    input  logic        BranchTaken_ID,
    input  logic        Jump_ID,
    input  logic        MemAccess_EX_MEM,
    input  logic        DMemReady,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        Bubble,
    output logic        PipeFreeze,
    output logic        MemWaitErr,
    output logic [15:0] StallCount,
    output logic [1:0]  State
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_t;
    state_t state;
    logic [7:0] waitCnt;
    logic [7:0] waitNext;
    logic loadUse;
    logic memBusy;
    logic freeze;
    assign loadUse = MemRead_ID_EX && Rt_ID_EX != 5'd0 &&
                     ((UsesRs_IF_ID && Rs_IF_ID == Rt_ID_EX) || (UsesRt_IF_ID && Rt_IF_ID == Rt_ID_EX));
    assign memBusy = MemAccess_EX_MEM && !DMemReady;
    assign freeze = (state == RUN && memBusy) || (state == MEM_WAIT && !DMemReady) || state == ERROR;
    assign waitNext = waitCnt + 8'd1;
    assign MemWaitErr = state == ERROR;
    assign State = state;
    // Reset masks every control output; freeze outranks load-use, which outranks redirects
    always_comb begin
        PipeFreeze = !Reset && freeze;
        PCWrite = !Reset && !freeze && !loadUse;
        IF_ID_Write = !Reset && !freeze && !loadUse;
        Bubble = !Reset && !freeze && loadUse;
        IF_ID_Flush = !Reset && !freeze && !loadUse && (BranchTaken_ID || Jump_ID);
    end
    always_ff @(negedge clk) begin
        if (Reset) begin
            state <= RUN;
            waitCnt <= 8'd0;
            StallCount <= 16'd0;
        end else begin
            if (!PCWrite && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
            case (state)
                RUN: if (memBusy) begin
                    state <= MEM_TIMEOUT == 1 ? ERROR : MEM_WAIT;
                    waitCnt <= 8'd1;
                end
                MEM_WAIT: if (DMemReady) begin
                    state <= RUN;
                    waitCnt <= 8'd0;
                end else begin
                    waitCnt <= waitNext;
                    if (waitNext == 8'(MEM_TIMEOUT)) state <= ERROR;
                end
                ERROR: state <= ERROR;
                default: state <= ERROR;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard control across MEM_TIMEOUT = 15, 4 and 1
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic Reset;
    logic MemRead_ID_EX;
    logic [4:0] Rt_ID_EX;
    logic [4:0] Rs_IF_ID;
    logic [4:0] Rt_IF_ID;
    logic UsesRs_IF_ID;
    logic UsesRt_IF_ID;
    logic BranchTaken_ID;
    logic Jump_ID;
    logic MemAccess_EX_MEM;
    logic DMemReady;
    logic pcw [3];
    logic ifw [3];
    logic fl [3];
    logic bub [3];
    logic pf [3];
    logic err [3];
    logic [15:0] sc [3];
    logic [1:0] st [3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // instance 0: MEM_TIMEOUT=15, 1: MEM_TIMEOUT=4, 2: MEM_TIMEOUT=1, all on the same inputs
    for (genvar g = 0; g < 3; g++) begin : gd
        pipe_hazard_ctrl #(.MEM_TIMEOUT(g == 0 ? 15 : (g == 1 ? 4 : 1))) u (
            .clk(clk), .Reset(Reset),
            .MemRead_ID_EX(MemRead_ID_EX), .Rt_ID_EX(Rt_ID_EX),
            .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
            .UsesRs_IF_ID(UsesRs_IF_ID), .UsesRt_IF_ID(UsesRt_IF_ID),
            .BranchTaken_ID(BranchTaken_ID), .Jump_ID(Jump_ID),
            .MemAccess_EX_MEM(MemAccess_EX_MEM), .DMemReady(DMemReady),
            .PCWrite(pcw[g]), .IF_ID_Write(ifw[g]), .IF_ID_Flush(fl[g]),
            .Bubble(bub[g]), .PipeFreeze(pf[g]), .MemWaitErr(err[g]),
            .StallCount(sc[g]), .State(st[g])
        );
    end

    task automatic setIn(input logic mr, input logic [4:0] rtEx, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uRs, input logic uRt, input logic br, input logic jmp,
                         input logic ma, input logic rdy);
        MemRead_ID_EX = mr; Rt_ID_EX = rtEx; Rs_IF_ID = rs; Rt_IF_ID = rt;
        UsesRs_IF_ID = uRs; UsesRt_IF_ID = uRt; BranchTaken_ID = br; Jump_ID = jmp;
        MemAccess_EX_MEM = ma; DMemReady = rdy;
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic doReset;
        Reset = 1'b1;
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        setIn(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (pcw[0] !== 1'b0) begin errors++; $display("FAIL rst_pcwrite: got %b expected 0", pcw[0]); end
        checks++; if (ifw[0] !== 1'b0) begin errors++; $display("FAIL rst_ifidwrite: got %b expected 0", ifw[0]); end
        checks++; if (bub[0] !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b expected 0", bub[0]); end
        checks++; if (fl[0] !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b expected 0", fl[0]); end
        checks++; if (pf[0] !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %b expected 0", pf[0]); end
        step;
        step;
        checks++; if (st[0] !== 2'b00) begin errors++; $display("FAIL rst_state: got %b expected 00", st[0]); end
        checks++; if (sc[0] !== 16'd0) begin errors++; $display("FAIL rst_stallcount: got %0d expected 0", sc[0]); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rst_memwaiterr: got %b expected 0", err[0]); end
        Reset = 1'b0;
    endtask

    task automatic test_load_use;
        doReset;
        setIn(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (bub[0] !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b expected 1", bub[0]); end
        checks++; if (pcw[0] !== 1'b0) begin errors++; $display("FAIL lu_pcwrite: got %b expected 0", pcw[0]); end
        checks++; if (ifw[0] !== 1'b0) begin errors++; $display("FAIL lu_ifidwrite: got %b expected 0", ifw[0]); end
        checks++; if (pf[0] !== 1'b0) begin errors++; $display("FAIL lu_freeze: got %b expected 0", pf[0]); end
        step;
        checks++; if (sc[0] !== 16'd1) begin errors++; $display("FAIL lu_stallcount: got %0d expected 1", sc[0]); end
        setIn(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (bub[0] !== 1'b0) begin errors++; $display("FAIL lu_after_bubble: got %b expected 0", bub[0]); end
        checks++; if (pcw[0] !== 1'b1) begin errors++; $display("FAIL lu_after_pcwrite: got %b expected 1", pcw[0]); end
        step;
        checks++; if (sc[0] !== 16'd1) begin errors++; $display("FAIL lu_after_stallcount: got %0d expected 1", sc[0]); end
    endtask

    task automatic test_no_stall;
        doReset;
        setIn(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (bub[0] !== 1'b0) begin errors++; $display("FAIL ns_r0_bubble: got %b expected 0", bub[0]); end
        checks++; if (pcw[0] !== 1'b1) begin errors++; $display("FAIL ns_r0_pcwrite: got %b expected 1", pcw[0]); end
        step;
        setIn(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (bub[0] !== 1'b0) begin errors++; $display("FAIL ns_unused_bubble: got %b expected 0", bub[0]); end
        checks++; if (pcw[0] !== 1'b1) begin errors++; $display("FAIL ns_unused_pcwrite: got %b expected 1", pcw[0]); end
        step;
        setIn(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (bub[0] !== 1'b1) begin errors++; $display("FAIL ns_rt_bubble: got %b expected 1", bub[0]); end
        step;
        checks++; if (sc[0] !== 16'd1) begin errors++; $display("FAIL ns_stallcount: got %0d expected 1", sc[0]); end
    endtask

    task automatic test_jump;
        doReset;
        setIn(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++; if (bub[0] !== 1'b1) begin errors++; $display("FAIL jlu_bubble: got %b expected 1", bub[0]); end
        checks++; if (fl[0] !== 1'b0) begin errors++; $display("FAIL jlu_flush: got %b expected 0", fl[0]); end
        checks++; if (pcw[0] !== 1'b0) begin errors++; $display("FAIL jlu_pcwrite: got %b expected 0", pcw[0]); end
        step;
        setIn(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++; if (fl[0] !== 1'b1) begin errors++; $display("FAIL j_flush: got %b expected 1", fl[0]); end
        checks++; if (pcw[0] !== 1'b1) begin errors++; $display("FAIL j_pcwrite: got %b expected 1", pcw[0]); end
        checks++; if (ifw[0] !== 1'b1) begin errors++; $display("FAIL j_ifidwrite: got %b expected 1", ifw[0]); end
        checks++; if (bub[0] !== 1'b0) begin errors++; $display("FAIL j_bubble: got %b expected 0", bub[0]); end
        step;
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (fl[0] !== 1'b1) begin errors++; $display("FAIL br_flush: got %b expected 1", fl[0]); end
        step;
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (fl[0] !== 1'b0) begin errors++; $display("FAIL idle_flush: got %b expected 0", fl[0]); end
        step;
        checks++; if (sc[0] !== 16'd1) begin errors++; $display("FAIL j_stallcount: got %0d expected 1", sc[0]); end
    endtask

    task automatic test_freeze_load_use;
        doReset;
        setIn(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (pf[0] !== 1'b1) begin errors++; $display("FAIL fl_freeze: got %b expected 1", pf[0]); end
        checks++; if (bub[0] !== 1'b0) begin errors++; $display("FAIL fl_bubble: got %b expected 0", bub[0]); end
        checks++; if (pcw[0] !== 1'b0) begin errors++; $display("FAIL fl_pcwrite: got %b expected 0", pcw[0]); end
        checks++; if (fl[0] !== 1'b0) begin errors++; $display("FAIL fl_flush: got %b expected 0", fl[0]); end
        step;
        checks++; if (st[0] !== 2'b01) begin errors++; $display("FAIL fl_state: got %b expected 01", st[0]); end
        setIn(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (pf[0] !== 1'b0) begin errors++; $display("FAIL fl_release_freeze: got %b expected 0", pf[0]); end
        checks++; if (bub[0] !== 1'b1) begin errors++; $display("FAIL fl_release_bubble: got %b expected 1", bub[0]); end
        step;
        checks++; if (st[0] !== 2'b00) begin errors++; $display("FAIL fl_release_state: got %b expected 00", st[0]); end
        checks++; if (sc[0] !== 16'd2) begin errors++; $display("FAIL fl_stallcount: got %0d expected 2", sc[0]); end
    endtask

    task automatic test_mem_wait;
        doReset;
        for (int i = 0; i < 3; i++) begin
            setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            checks++; if (pf[0] !== 1'b1) begin errors++; $display("FAIL mw_freeze[%0d]: got %b expected 1", i, pf[0]); end
            checks++; if (pcw[0] !== 1'b0) begin errors++; $display("FAIL mw_pcwrite[%0d]: got %b expected 0", i, pcw[0]); end
            step;
            checks++; if (st[0] !== 2'b01) begin errors++; $display("FAIL mw_state[%0d]: got %b expected 01", i, st[0]); end
            checks++; if (st[2] !== 2'b10) begin errors++; $display("FAIL mw_t1_state[%0d]: got %b expected 10", i, st[2]); end
        end
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (pf[0] !== 1'b0) begin errors++; $display("FAIL mw_done_freeze: got %b expected 0", pf[0]); end
        checks++; if (pcw[0] !== 1'b1) begin errors++; $display("FAIL mw_done_pcwrite: got %b expected 1", pcw[0]); end
        checks++; if (pf[2] !== 1'b1) begin errors++; $display("FAIL mw_t1_freeze: got %b expected 1", pf[2]); end
        step;
        checks++; if (st[0] !== 2'b00) begin errors++; $display("FAIL mw_done_state: got %b expected 00", st[0]); end
        checks++; if (st[1] !== 2'b00) begin errors++; $display("FAIL mw_t4_state: got %b expected 00", st[1]); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL mw_err: got %b expected 0", err[0]); end
        checks++; if (err[2] !== 1'b1) begin errors++; $display("FAIL mw_t1_err: got %b expected 1", err[2]); end
        checks++; if (sc[0] !== 16'd3) begin errors++; $display("FAIL mw_stallcount: got %0d expected 3", sc[0]); end
    endtask

    task automatic test_timeout;
        doReset;
        for (int i = 0; i < 4; i++) begin
            setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            checks++; if (pf[1] !== 1'b1) begin errors++; $display("FAIL to_freeze[%0d]: got %b expected 1", i, pf[1]); end
            step;
            checks++; if (st[1] !== (i == 3 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL to_state[%0d]: got %b", i, st[1]); end
            checks++; if (err[1] !== (i == 3)) begin errors++; $display("FAIL to_err[%0d]: got %b", i, err[1]); end
        end
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (pf[1] !== 1'b1) begin errors++; $display("FAIL to_sticky_freeze: got %b expected 1", pf[1]); end
        checks++; if (pcw[1] !== 1'b0) begin errors++; $display("FAIL to_sticky_pcwrite: got %b expected 0", pcw[1]); end
        step;
        checks++; if (st[1] !== 2'b10) begin errors++; $display("FAIL to_sticky_state: got %b expected 10", st[1]); end
        checks++; if (sc[1] !== 16'd5) begin errors++; $display("FAIL to_stallcount: got %0d expected 5", sc[1]); end
        Reset = 1'b1;
        #1;
        checks++; if (pf[1] !== 1'b0) begin errors++; $display("FAIL to_rst_freeze: got %b expected 0", pf[1]); end
        step;
        checks++; if (st[1] !== 2'b00) begin errors++; $display("FAIL to_rst_state: got %b expected 00", st[1]); end
        checks++; if (sc[1] !== 16'd0) begin errors++; $display("FAIL to_rst_stallcount: got %0d expected 0", sc[1]); end
        checks++; if (err[1] !== 1'b0) begin errors++; $display("FAIL to_rst_err: got %b expected 0", err[1]); end
        Reset = 1'b0;
    endtask

    task automatic test_saturate;
        doReset;
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (65534) @(negedge clk);
        #1;
        checks++; if (sc[1] !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", sc[1]); end
        step;
        checks++; if (sc[1] !== 16'hFFFF) begin errors++; $display("FAIL sat_top: got %h expected ffff", sc[1]); end
        repeat (4) @(negedge clk);
        #1;
        checks++; if (sc[1] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_t4: got %h expected ffff", sc[1]); end
        checks++; if (sc[0] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_t15: got %h expected ffff", sc[0]); end
        checks++; if (sc[2] !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_t1: got %h expected ffff", sc[2]); end
    endtask

    initial begin
        Reset = 1'b1;
        setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        test_reset;
        test_load_use;
        test_no_stall;
        test_jump;
        test_freeze_load_use;
        test_mem_wait;
        test_timeout;
        test_saturate;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
